fpu_share_arbiter: RTL and testbench
====================================

Name: fpu_share_arbiter

Overview:
Shares one multi-cycle FPU core (one-hot 8-bit opcode, x1/x2 operands, y result, out_valid strobe) between two requesters, e.g. the execute stage and a second issue port.
- Round-robin arbitration.
- Valid/ready handshake on both the request and response sides.
- Translates the 5-bit alu_control FP encoding into the FPU one-hot opcode.
- Holds each result until the owning requester accepts it.

Parameters:
- TIMEOUT, 64, WAIT-state cycle limit before aborting an FPU operation (used only with FPU_TIMEOUT_EN).
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_op0, req_op1  in  5 each  alu_control-format op for requester 0/1.
- req_a0, req_a1  in  32 each  operand a per requester.
- req_b0, req_b1  in  32 each  operand b per requester.
- req_ready  out  2  request accepted this cycle, one-hot or zero.
- rsp_valid  out  2  result available for requester i, one-hot or zero.
- rsp_data  out  32  result data, valid when any rsp_valid bit is set.
- rsp_err  out  1  result aborted by timeout; qualifies rsp_valid.
- rsp_ready  in  2  requester i accepts its result.
- fpu_opcode  out  8  one-hot FPU opcode; 0 means no operation.
- fpu_x1  out  32  FPU operand 1.
- fpu_x2  out  32  FPU operand 2.
- fpu_y  in  32  FPU result.
- fpu_out_valid  in  1  FPU result strobe.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0 (requester 0 has priority), all registers cleared.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, fpu_opcode=0, fpu_x1=0, fpu_x2=0, busy=0.
  - Reset mid-operation abandons the operation. fpu_out_valid pulses arriving in IDLE afterwards are ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = the requester with req_valid set. If both are set, grant = rr_ptr.
  - req_ready[grant]=1 combinationally, only in IDLE. The handshake completes that cycle.
  - Latch op, a, b and owner=grant. If the op is legal, go to ISSUE; otherwise go to RESP with result 0 and no FPU issue.
- Opcode map (alu_control -> fpu_opcode):
  - 10000->0x01, 10001->0x02, 10010->0x04, 10011->0x08
  - 11011->0x10, 10110->0x20, 10111->0x40, 10101->0x80
  - Any other value is illegal.
- ISSUE (exactly 1 cycle):
  - fpu_opcode = mapped one-hot value, fpu_x1=a, fpu_x2=b, all registered outputs.
  - Next state WAIT.
  - fpu_out_valid in ISSUE is ignored; the FPU latency is at least 1 cycle after the opcode.
- WAIT:
  - fpu_opcode=0. fpu_x1/fpu_x2 hold their values until the state leaves WAIT.
  - On fpu_out_valid=1: capture fpu_y into the result register, go to RESP.
- RESP:
  - rsp_valid[owner]=1, rsp_data=result. Both stay stable until rsp_ready[owner]=1.
  - rsp_ready on the non-owner bit is ignored.
  - On acceptance: go to IDLE, set rr_ptr = ~owner.
  - No new request is granted in the same cycle as the response acceptance.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Latency from accept cycle T: fpu_opcode pulse at T+1. If out_valid arrives at T+1+L, rsp_valid rises at T+2+L. An illegal op gives rsp_valid at T+1.
- Only one operation is in flight; there is no pipelining of FPU operations.
- Request operands may change after the handshake without affecting the operation.

Optional Feature:
- Macro: FPU_TIMEOUT_EN.
- Defined:
  - CNT_W counter clears on entry to WAIT and increments each WAIT cycle without fpu_out_valid.
  - When the count reaches TIMEOUT: go to RESP with rsp_data=32'hFFFFFFFF and rsp_err=1.
  - A late fpu_out_valid after the abort is ignored.
  - rsp_err clears on response acceptance.
- Undefined: no counter. WAIT lasts indefinitely and rsp_err is tied to 0.

Test Plan:
1. Reset, then req_valid=01, op=10000, a=3F800000, b=40000000; FPU model returns y=40400000 after 3 cycles. Expect: req_ready=01 at T, fpu_opcode=0x01 only at T+1, rsp_valid=01 with rsp_data=40400000 at T+5.
2. Both requesters continuously valid for 4 operations, rsp_ready tied 1. Expect: grant order 0,1,0,1 and fpu_opcode pulses in sequence, one per operation.
3. Illegal op 10100 from requester 1. Expect: fpu_opcode stays 0, rsp_valid=10 with rsp_data=0 one cycle after acceptance.
4. Hold rsp_ready=00 for 5 cycles in RESP while req_valid=01 is asserted. Expect: rsp_valid and rsp_data stable, req_ready=00, busy=1. Assert rsp_ready: returns to IDLE, grant follows.
5. Assert rst during WAIT, then a stray fpu_out_valid in IDLE. Expect: all outputs 0, no rsp_valid, next request proceeds normally.
6. With FPU_TIMEOUT_EN and TIMEOUT=8, the FPU never responds. Expect: after 8 WAIT cycles, rsp_valid with rsp_data=FFFFFFFF and rsp_err=1. A late out_valid has no effect.

Source files
------------

// File: rtl/fpu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_share_arbiter: round-robin sharing of one multi-cycle FPU core by two   |
// | requesters. Optional macro FPU_TIMEOUT_EN adds a WAIT-state abort timer.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fpu_share_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [4:0]  req_op0,
  input  logic [4:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic [1:0]  rsp_ready,
  output logic [7:0]  fpu_opcode,
  output logic [31:0] fpu_x1,
  output logic [31:0] fpu_x2,
  input  logic [31:0] fpu_y,
  input  logic        fpu_out_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  if ((2 ** CNT_W) <= TIMEOUT) begin : g_cnt_w_check
    $error("fpu_share_arbiter: CNT_W too narrow to hold TIMEOUT");
  end

  state_t      state_q;
  logic        rr_q;
  logic        owner_q;
  logic [7:0]  opcode_q;
  logic [31:0] x1_q;
  logic [31:0] x2_q;
  logic [31:0] result_q;
`ifdef FPU_TIMEOUT_EN
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
`endif

  logic [1:0]  grant;
  logic        sel;
  logic [4:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [7:0]  sel_onehot;

  function automatic logic [7:0] map_op(input logic [4:0] op);
    logic [7:0] oh;
    oh = 8'h00;
    case (op)
      5'b10000: oh = 8'h01;
      5'b10001: oh = 8'h02;
      5'b10010: oh = 8'h04;
      5'b10011: oh = 8'h08;
      5'b11011: oh = 8'h10;
      5'b10110: oh = 8'h20;
      5'b10111: oh = 8'h40;
      5'b10101: oh = 8'h80;
      default:  oh = 8'h00;
    endcase
    return oh;
  endfunction

  // Grants only exist in IDLE; rr_q breaks the tie when both requesters are valid.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign sel        = grant[1];
  assign sel_op     = sel ? req_op1 : req_op0;
  assign sel_a      = sel ? req_a1  : req_a0;
  assign sel_b      = sel ? req_b1  : req_b0;
  assign sel_onehot = map_op(sel_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      opcode_q <= 8'h00;
      x1_q     <= 32'h0;
      x2_q     <= 32'h0;
      result_q <= 32'h0;
`ifdef FPU_TIMEOUT_EN
      err_q    <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            owner_q <= sel;
            if (sel_onehot != 8'h00) begin
              opcode_q <= sel_onehot;
              x1_q     <= sel_a;
              x2_q     <= sel_b;
              state_q  <= ISSUE;
            end else begin
              // Illegal op: answer with zero and never touch the FPU.
              result_q <= 32'h0;
              state_q  <= RESP;
            end
          end
        end
        ISSUE: begin
          opcode_q <= 8'h00;
`ifdef FPU_TIMEOUT_EN
          cnt_q    <= '0;
`endif
          state_q  <= WAIT;
        end
        WAIT: begin
          if (fpu_out_valid) begin
            result_q <= fpu_y;
            state_q  <= RESP;
          end
`ifdef FPU_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            result_q <= 32'hFFFF_FFFF;
            err_q    <= 1'b1;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            rr_q    <= ~owner_q;
`ifdef FPU_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data   = (state_q == RESP) ? result_q : 32'h0;
`ifdef FPU_TIMEOUT_EN
  assign rsp_err    = (state_q == RESP) && err_q;
`else
  assign rsp_err    = 1'b0;
`endif
  assign fpu_opcode = opcode_q;
  assign fpu_x1     = x1_q;
  assign fpu_x2     = x2_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fpu_share_arbiter: directed stimulus, timeline model and FPU stub for    |
// | fpu_share_arbiter. Revision: 1.0                                            |
// +----------------------------------------------------------------------------+
module tb_fpu_share_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [4:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  rsp_ready;
  logic [7:0]  fpu_opcode;
  logic [31:0] fpu_x1, fpu_x2;
  logic [31:0] fpu_y;
  logic        fpu_out_valid;
  logic        busy;

  always #5 clk = ~clk;

  fpu_share_arbiter #(.TIMEOUT(TO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
    .fpu_y(fpu_y), .fpu_out_valid(fpu_out_valid),
    .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // alu_control codes in order of the one-hot bit they select.
  function automatic logic [7:0] ref_map(input logic [4:0] op);
    int codes[8] = '{16, 17, 18, 19, 27, 22, 23, 21};
    for (int i = 0; i < 8; i++)
      if (int'(op) == codes[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  function automatic logic [31:0] stub_fn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 8'h01 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ {24'h0, op};
  endfunction

  // FPU stub: answers fpu_lat cycles after the opcode cycle unless muted.
  int          fpu_lat   = 2;
  bit          fpu_mute  = 1'b0;
  int          force_req = 0;
  int          force_seen = 0;
  int          fpu_cnt   = 0;
  logic [31:0] fpu_res   = 32'h0;

  initial begin : fpu_stub
    fpu_out_valid = 1'b0;
    fpu_y         = 32'h0;
    forever begin
      @(negedge clk);
      if (fpu_opcode != 8'h00 && !fpu_mute) begin
        fpu_cnt = fpu_lat;
        fpu_res = stub_fn(fpu_opcode, fpu_x1, fpu_x2);
      end
      @(posedge clk);
      #1;
      fpu_out_valid = (force_req != force_seen);
      force_seen    = force_req;
      if (fpu_cnt > 0) begin
        fpu_cnt--;
        if (fpu_cnt == 0) begin
          fpu_out_valid = 1'b1;
          fpu_y         = fpu_res;
        end
      end
    end
  end

  // Timeline model: each operation is an accept cycle plus a response cycle.
  bit          m_busy = 1'b0;
  bit          m_rr   = 1'b0;
  bit          m_own  = 1'b0;
  int          m_tacc = 0;
  int          m_trsp = -1;
  logic [7:0]  m_op   = 8'h00;
  logic [31:0] m_pa = 32'h0, m_pb = 32'h0, m_x1 = 32'h0, m_x2 = 32'h0, m_res = 32'h0;
  bit          m_err  = 1'b0;
  int          grants[$];
  int          ops[$];

  initial begin : compare
    logic [1:0]  e_ready, e_rv;
    logic [31:0] e_data;
    logic        e_err, e_busy;
    logic [7:0]  e_op;
    bit          own;
    forever begin
      @(negedge clk);
      cyc++;
      e_ready = 2'b00; e_rv = 2'b00; e_data = 32'h0; e_err = 1'b0; e_op = 8'h00; e_busy = 1'b0;
      own = 1'b0;
      if (rst) begin
        m_busy = 1'b0; m_rr = 1'b0; m_x1 = 32'h0; m_x2 = 32'h0;
      end else if (!m_busy) begin
        if (req_valid != 2'b00) begin
          own = (req_valid == 2'b11) ? m_rr : req_valid[1];
          e_ready = own ? 2'b10 : 2'b01;
        end
      end else begin
        e_busy = 1'b1;
        if (cyc == m_tacc + 1 && m_op != 8'h00) begin
          e_op = m_op; m_x1 = m_pa; m_x2 = m_pb;
        end
        if (m_trsp >= 0 && cyc >= m_trsp) begin
          e_rv = m_own ? 2'b10 : 2'b01; e_data = m_res; e_err = m_err;
        end
      end

      chk("req_ready",  32'(req_ready),  32'(e_ready));
      chk("rsp_valid",  32'(rsp_valid),  32'(e_rv));
      chk("rsp_data",   rsp_data,        e_data);
      chk("rsp_err",    32'(rsp_err),    32'(e_err));
      chk("fpu_opcode", 32'(fpu_opcode), 32'(e_op));
      chk("fpu_x1",     fpu_x1,          m_x1);
      chk("fpu_x2",     fpu_x2,          m_x2);
      chk("busy",       32'(busy),       32'(e_busy));

      if (req_ready != 2'b00) grants.push_back(int'(req_ready[1]));
      if (fpu_opcode != 8'h00) ops.push_back(int'(fpu_opcode));

      if (rst) begin
      end else if (!m_busy) begin
        if (req_valid != 2'b00) begin
          m_busy = 1'b1; m_own = own; m_tacc = cyc; m_err = 1'b0;
          m_op = ref_map(own ? req_op1 : req_op0);
          m_pa = own ? req_a1 : req_a0;
          m_pb = own ? req_b1 : req_b0;
          if (m_op == 8'h00) begin m_trsp = cyc + 1; m_res = 32'h0; end
          else m_trsp = -1;
        end
      end else if (m_trsp >= 0 && cyc >= m_trsp) begin
        if (rsp_ready[m_own]) begin m_busy = 1'b0; m_rr = ~m_own; end
      end else if (m_trsp < 0 && cyc >= m_tacc + 2) begin
        if (fpu_out_valid) begin
          m_trsp = cyc + 1; m_res = fpu_y;
        end
`ifdef FPU_TIMEOUT_EN
        else if (cyc == m_tacc + 1 + TO) begin
          m_trsp = cyc + 1; m_res = 32'hFFFF_FFFF; m_err = 1'b1;
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp(input int max);
    int k = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && k < max) begin
      @(negedge clk);
      k++;
    end
    if (rsp_valid == 2'b00) chk("wait_rsp_bound", 32'(k), 32'(-1));
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    @(negedge clk);
    while (busy && k < max) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("wait_idle_bound", 32'(k), 32'(-1));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g0, o0;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op0 = 5'd0; req_op1 = 5'd0;
    req_a0 = 32'h0; req_a1 = 32'h0; req_b0 = 32'h0; req_b1 = 32'h0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    tick(); rst = 1'b0;

    // 1: single op from requester 0, FPU latency 3
    tick();
    fpu_lat = 3; req_valid = 2'b01; req_op0 = 5'b10000;
    req_a0 = 32'h3F80_0000; req_b0 = 32'h4000_0000;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00; req_a0 = 32'hDEAD_BEEF; req_b0 = 32'h0;
    @(negedge clk);
    chk("t1_opcode_t1", 32'(fpu_opcode), 32'h01);
    chk("t1_x1", fpu_x1, 32'h3F80_0000);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk("t1_opcode_idle", 32'(fpu_opcode), 32'h0);
      if (k < 5) chk("t1_rsp_early", 32'(rsp_valid), 32'h0);
    end
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_data", rsp_data, 32'h4040_0000);
    tick(); rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;

    // 2: fairness with both requesters always valid
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    tick();
    g0 = grants.size(); o0 = ops.size();
    fpu_lat = 1; req_op0 = 5'b10001; req_op1 = 5'b11011;
    req_a0 = 32'h1111_0000; req_b0 = 32'h0000_2222;
    req_a1 = 32'hA5A5_0F0F; req_b1 = 32'h1234_5678;
    rsp_ready = 2'b11; req_valid = 2'b11;
    for (int k = 0; k < 200 && grants.size() < g0 + 4; k++) @(negedge clk);
    tick(); req_valid = 2'b00;
    wait_idle(50);
    chk("t2_grant_count", 32'(grants.size() - g0), 32'd4);
    chk("t2_op_count", 32'(ops.size() - o0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (g0 + i < grants.size()) chk("t2_grant_order", 32'(grants[g0 + i]), 32'(i % 2));
      if (o0 + i < ops.size()) chk("t2_opcode_seq", 32'(ops[o0 + i]), (i % 2 == 1) ? 32'h10 : 32'h02);
    end

    // 3 and 4: illegal op from requester 1, then held response
    tick(); rsp_ready = 2'b00; fpu_lat = 2;
    req_valid = 2'b10; req_op1 = 5'b10100; req_a1 = 32'h1; req_b1 = 32'h2;
    @(negedge clk);
    chk("t3_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = 2'b01; req_op0 = 5'b10010; req_a0 = 32'h0BAD_F00D; req_b0 = 32'h7777_1111;
    @(negedge clk);
    chk("t3_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t3_rsp_data", rsp_data, 32'h0);
    chk("t3_no_issue", 32'(fpu_opcode), 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(rsp_valid), 32'h2);
      chk("t4_hold_ready", 32'(req_ready), 32'h0);
      chk("t4_hold_busy", 32'(busy), 32'h1);
    end
    tick(); rsp_ready = 2'b01;
    @(negedge clk);
    chk("t4_non_owner_ignored", 32'(rsp_valid), 32'h2);
    tick(); rsp_ready = 2'b10;
    @(negedge clk);
    chk("t4_accept_no_grant", 32'(req_ready), 32'h0);
    tick(); rsp_ready = 2'b00;
    @(negedge clk);
    chk("t4_grant_follows", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00;
    wait_rsp(20);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t4_rsp_data", rsp_data, stub_fn(8'h04, 32'h0BAD_F00D, 32'h7777_1111));
    tick(); rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;

    // 5: reset during WAIT, then stray FPU strobes in IDLE
    tick(); fpu_lat = 3; req_valid = 2'b01; req_op0 = 5'b10011;
    @(negedge clk);
    chk("t5_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00;
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_opcode", 32'(fpu_opcode), 32'h0);
    chk("t5_rst_x1", fpu_x1, 32'h0);
    tick(); rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_stray_rsp", 32'(rsp_valid), 32'h0);
      chk("t5_stray_busy", 32'(busy), 32'h0);
    end
    tick(); force_req++;
    repeat (2) begin
      @(negedge clk);
      chk("t5_forced_rsp", 32'(rsp_valid), 32'h0);
    end
    tick(); req_valid = 2'b01; req_op0 = 5'b10000;
    req_a0 = 32'h3F80_0000; req_b0 = 32'h4000_0000;
    @(negedge clk);
    chk("t5_next_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00;
    wait_rsp(20);
    chk("t5_next_data", rsp_data, 32'h4040_0000);
    tick(); rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;

`ifdef FPU_TIMEOUT_EN
    // 6: FPU never answers
    tick(); fpu_mute = 1'b1; req_valid = 2'b01; req_op0 = 5'b10111;
    @(negedge clk);
    chk("t6_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      if (k < 10) chk("t6_rsp_early", 32'(rsp_valid), 32'h0);
    end
    chk("t6_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t6_rsp_data", rsp_data, 32'hFFFF_FFFF);
    chk("t6_rsp_err", 32'(rsp_err), 32'h1);
    tick(); force_req++;
    repeat (3) begin
      @(negedge clk);
      chk("t6_late_data", rsp_data, 32'hFFFF_FFFF);
      chk("t6_late_err", 32'(rsp_err), 32'h1);
    end
    tick(); rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00; fpu_mute = 1'b0;
    @(negedge clk);
    chk("t6_err_cleared", 32'(rsp_err), 32'h0);
    chk("t6_idle", 32'(busy), 32'h0);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
